sram_to_axi_master: RTL and testbench

- Single-outstanding AXI4 initiator (64-bit data, 32-bit address). It converts SRAM-style requests (CEn/WEn/ADDR/WDATA/WBEn) into single-beat AXI4 read or write transactions.
- It is the initiator-side counterpart of the existing AXI-to-SRAM responder. It lets a local controller, such as a GCD result packer or a test sequencer, drive any AXI4 slave in the design through the same SRAM-style signal set.
- It adds a ready/ack handshake on the SRAM side, because AXI latency is unbounded.

---
 rtl/sram_to_axi_master_if.sv | 73 +++++++
 rtl/sram_to_axi_master.sv | 203 ++++++++++++++++++++
 tb/tb_sram_to_axi_master.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_to_axi_master_if.sv
// AXI4 master-side bus bundle (64-bit data, 32-bit address) for sram_to_axi_master.
// Ports: none; master modport drives AW/W/AR channels and B/R ready, slave modport mirrors it.
interface sram_to_axi_master_if;
    logic [3:0]  M_AXI_AWID;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [3:0]  M_AXI_BID;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [3:0]  M_AXI_ARID;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARLOCK;
    logic [3:0]  M_AXI_ARCACHE;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [3:0]  M_AXI_RID;
    logic [63:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
        output M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT,
        output M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
        output M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT,
        output M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
        input  M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT,
        input  M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
        input  M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT,
        input  M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/sram_to_axi_master.sv
// Single-outstanding AXI4 initiator driven by an SRAM-style request port.
// Ports: CLK/RESETn; SRAM_CEn/WEn/ADDR/WDATA/WBEn in; SRAM_READY/ACK/ERR/RDATA out;
//        m_axi (master modport) carries the AW/W/B/AR/R channels.
module sram_to_axi_master #(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        SRAM_CEn,
    input  logic        SRAM_WEn,
    input  logic [31:0] SRAM_ADDR,
    input  logic [63:0] SRAM_WDATA,
    input  logic [7:0]  SRAM_WBEn,
    output logic        SRAM_READY,
    output logic        SRAM_ACK,
    output logic        SRAM_ERR,
    output logic [63:0] SRAM_RDATA,
    sram_to_axi_master_if.master m_axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_err;
    logic        r_ack;
    logic [63:0] r_rdata;

    logic        w_ready;
    logic        w_accept;
    logic        w_awvalid;
    logic        w_wvalid;
    logic        w_bready;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_b_hs;
    logic        w_r_hs;
    logic        w_b_err;
    logic        w_r_err;
    logic [31:0] w_addr_al;

    // Low three address bits are dropped: every beat is a full 64-bit word.
    assign w_addr_al = SRAM_ADDR & 32'hFFFF_FFF8;

    assign w_b_err = (m_axi.M_AXI_BRESP >= 2'b10)
                   | (m_axi.M_AXI_BID != AXI_ID);
    assign w_r_err = (m_axi.M_AXI_RRESP >= 2'b10)
                   | (m_axi.M_AXI_RID != AXI_ID)
                   | ~m_axi.M_AXI_RLAST;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (!SRAM_CEn) begin
                    w_next = SRAM_WEn ? RD_ADDR : WR_ADDR_DATA;
                end
            end
            WR_ADDR_DATA: begin
                w_awvalid = ~r_aw_done;
                w_wvalid  = ~r_w_done;
                if ((r_aw_done | (w_awvalid & m_axi.M_AXI_AWREADY)) &&
                    (r_w_done  | (w_wvalid  & m_axi.M_AXI_WREADY))) begin
                    w_next = WR_RESP;
                end
            end
            WR_RESP: begin
                w_bready = 1'b1;
                if (m_axi.M_AXI_BVALID) begin
                    w_next = IDLE;
                end
            end
            RD_ADDR: begin
                w_arvalid = 1'b1;
                if (m_axi.M_AXI_ARREADY) begin
                    w_next = RD_DATA;
                end
            end
            RD_DATA: begin
                w_rready = 1'b1;
                if (m_axi.M_AXI_RVALID && m_axi.M_AXI_RLAST) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_accept = w_ready & ~SRAM_CEn;
    assign w_aw_hs  = w_awvalid & m_axi.M_AXI_AWREADY;
    assign w_w_hs   = w_wvalid & m_axi.M_AXI_WREADY;
    assign w_b_hs   = w_bready & m_axi.M_AXI_BVALID;
    assign w_r_hs   = w_rready & m_axi.M_AXI_RVALID;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack <= 1'b0;
            if (w_accept) begin
                r_addr  <= w_addr_al;
                r_wdata <= SRAM_WDATA;
                r_wstrb <= ~SRAM_WBEn;
                r_err   <= 1'b0;
            end
            // Done flags let AW and W complete in either order.
            if (r_state == WR_ADDR_DATA) begin
                if (w_next == WR_RESP) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    r_aw_done <= r_aw_done | w_aw_hs;
                    r_w_done  <= r_w_done | w_w_hs;
                end
            end
            if (w_b_hs) begin
                r_err <= w_b_err;
                r_ack <= 1'b1;
            end
            // Non-last beats are drained and only poison the error flag.
            if (w_r_hs) begin
                r_err <= r_err | w_r_err;
                if (m_axi.M_AXI_RLAST) begin
                    r_rdata <= m_axi.M_AXI_RDATA;
                    r_ack   <= 1'b1;
                end
            end
        end
    end

    assign SRAM_READY = w_ready;
    assign SRAM_ACK   = r_ack;
    assign SRAM_ERR   = r_ack & r_err;
    assign SRAM_RDATA = r_rdata;

    assign m_axi.M_AXI_AWID    = AXI_ID;
    assign m_axi.M_AXI_AWADDR  = r_addr;
    assign m_axi.M_AXI_AWLEN   = 8'd0;
    assign m_axi.M_AXI_AWSIZE  = 3'b011;
    assign m_axi.M_AXI_AWBURST = 2'b01;
    assign m_axi.M_AXI_AWLOCK  = 1'b0;
    assign m_axi.M_AXI_AWCACHE = 4'd0;
    assign m_axi.M_AXI_AWPROT  = 3'd0;
    assign m_axi.M_AXI_AWVALID = w_awvalid;

    assign m_axi.M_AXI_WDATA   = r_wdata;
    assign m_axi.M_AXI_WSTRB   = r_wstrb;
    assign m_axi.M_AXI_WLAST   = 1'b1;
    assign m_axi.M_AXI_WVALID  = w_wvalid;

    assign m_axi.M_AXI_BREADY  = w_bready;

    assign m_axi.M_AXI_ARID    = AXI_ID;
    assign m_axi.M_AXI_ARADDR  = r_addr;
    assign m_axi.M_AXI_ARLEN   = 8'd0;
    assign m_axi.M_AXI_ARSIZE  = 3'b011;
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARLOCK  = 1'b0;
    assign m_axi.M_AXI_ARCACHE = 4'd0;
    assign m_axi.M_AXI_ARPROT  = 3'd0;
    assign m_axi.M_AXI_ARVALID = w_arvalid;

    assign m_axi.M_AXI_RREADY  = w_rready;

endmodule

// File: tb/tb_sram_to_axi_master.sv
// Self-checking bench for sram_to_axi_master: AXI slave model plus scoreboard.
// Ports: none.
module tb_sram_to_axi_master;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        SRAM_CEn;
    logic        SRAM_WEn;
    logic [31:0] SRAM_ADDR;
    logic [63:0] SRAM_WDATA;
    logic [7:0]  SRAM_WBEn;
    logic        SRAM_READY;
    logic        SRAM_ACK;
    logic        SRAM_ERR;
    logic [63:0] SRAM_RDATA;

    sram_to_axi_master_if axi ();

    sram_to_axi_master #(.AXI_ID(4'h0)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .SRAM_CEn   (SRAM_CEn),
        .SRAM_WEn   (SRAM_WEn),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WDATA (SRAM_WDATA),
        .SRAM_WBEn  (SRAM_WBEn),
        .SRAM_READY (SRAM_READY),
        .SRAM_ACK   (SRAM_ACK),
        .SRAM_ERR   (SRAM_ERR),
        .SRAM_RDATA (SRAM_RDATA),
        .m_axi      (axi.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] ar_q[$];
    logic [71:0] w_q[$];
    logic [63:0] model_rd;

    int n_cmp = 0;
    int n_bad = 0;

    int aw_delay, w_delay, b_delay, r_beats;
    logic [1:0]  bresp, rresp;
    logic [3:0]  bid, rid;
    logic [63:0] rdata_cfg;

    int aw_cnt, w_cnt, b_wait, r_left;
    logic aw_got, w_got;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    int aw_hi, w_hi, bready_early, ack_cnt, acks_exp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // AXI slave model and output monitor
    initial begin
        axi.M_AXI_AWREADY = 1'b0;
        axi.M_AXI_WREADY  = 1'b0;
        axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_BVALID  = 1'b0;
        axi.M_AXI_BID     = '0;
        axi.M_AXI_BRESP   = '0;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RID     = '0;
        axi.M_AXI_RRESP   = '0;
        axi.M_AXI_RLAST   = 1'b0;
        axi.M_AXI_RDATA   = '0;
        aw_cnt = 0; w_cnt = 0; b_wait = 0; r_left = 0;
        aw_got = 0; w_got = 0;
        aw_hi = 0; w_hi = 0; bready_early = 0; ack_cnt = 0;
        forever begin
            @(negedge CLK);
            aw_hs = axi.M_AXI_AWVALID & axi.M_AXI_AWREADY;
            w_hs  = axi.M_AXI_WVALID & axi.M_AXI_WREADY;
            ar_hs = axi.M_AXI_ARVALID & axi.M_AXI_ARREADY;
            b_hs  = axi.M_AXI_BVALID & axi.M_AXI_BREADY;
            r_hs  = axi.M_AXI_RVALID & axi.M_AXI_RREADY;
            if (RESETn) begin
                aw_hi += int'(axi.M_AXI_AWVALID);
                w_hi  += int'(axi.M_AXI_WVALID);
                if (axi.M_AXI_BREADY && !(aw_got && w_got))
                    bready_early++;
                if (aw_hs) begin
                    chk("aw_expected", aw_q.size() > 0, 1);
                    if (aw_q.size() > 0)
                        chk("awaddr", axi.M_AXI_AWADDR, aw_q.pop_front());
                    chk("aw_ctl", {axi.M_AXI_AWID, axi.M_AXI_AWLEN,
                        axi.M_AXI_AWSIZE, axi.M_AXI_AWBURST,
                        axi.M_AXI_AWLOCK, axi.M_AXI_AWCACHE,
                        axi.M_AXI_AWPROT},
                        {4'h0, 8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0});
                end
                if (w_hs) begin
                    chk("w_expected", w_q.size() > 0, 1);
                    if (w_q.size() > 0) begin
                        logic [71:0] e;
                        e = w_q.pop_front();
                        chk("wdata", axi.M_AXI_WDATA, e[71:8]);
                        chk("wstrb_wlast", {axi.M_AXI_WSTRB, axi.M_AXI_WLAST},
                            {e[7:0], 1'b1});
                    end
                end
                if (ar_hs) begin
                    chk("ar_expected", ar_q.size() > 0, 1);
                    if (ar_q.size() > 0)
                        chk("araddr", axi.M_AXI_ARADDR, ar_q.pop_front());
                    chk("ar_ctl", {axi.M_AXI_ARID, axi.M_AXI_ARLEN,
                        axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST,
                        axi.M_AXI_ARLOCK, axi.M_AXI_ARCACHE,
                        axi.M_AXI_ARPROT},
                        {4'h0, 8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0});
                end
                if (SRAM_ACK) begin
                    ack_cnt++;
                    chk("ack_expected", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("ack_err", SRAM_ERR, e.err);
                        chk("ack_rdata", SRAM_RDATA, e.rdata);
                    end
                end
            end
            @(posedge CLK);
            #1;
            if (!RESETn) begin
                axi.M_AXI_AWREADY = 1'b0;
                axi.M_AXI_WREADY  = 1'b0;
                axi.M_AXI_ARREADY = 1'b0;
                axi.M_AXI_BVALID  = 1'b0;
                axi.M_AXI_RVALID  = 1'b0;
                aw_cnt = 0; w_cnt = 0; b_wait = 0; r_left = 0;
                aw_got = 0; w_got = 0;
            end else begin
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (axi.M_AXI_AWVALID) begin
                    axi.M_AXI_AWREADY = (aw_cnt >= aw_delay);
                    aw_cnt++;
                end else begin
                    axi.M_AXI_AWREADY = 1'b0;
                    aw_cnt = 0;
                end
                if (axi.M_AXI_WVALID) begin
                    axi.M_AXI_WREADY = (w_cnt >= w_delay);
                    w_cnt++;
                end else begin
                    axi.M_AXI_WREADY = 1'b0;
                    w_cnt = 0;
                end
                axi.M_AXI_ARREADY = axi.M_AXI_ARVALID;
                if (b_hs) begin
                    axi.M_AXI_BVALID = 1'b0;
                    aw_got = 0; w_got = 0; b_wait = 0;
                end else if (aw_got && w_got && !axi.M_AXI_BVALID) begin
                    if (b_wait >= b_delay) axi.M_AXI_BVALID = 1'b1;
                    else b_wait++;
                end
                axi.M_AXI_BID   = bid;
                axi.M_AXI_BRESP = bresp;
                if (ar_hs) r_left = r_beats;
                else if (r_hs) r_left--;
                axi.M_AXI_RVALID = (r_left > 0);
                axi.M_AXI_RLAST  = (r_left == 1);
                axi.M_AXI_RDATA  = (r_left == 1) ? rdata_cfg : ~rdata_cfg;
                axi.M_AXI_RID    = rid;
                axi.M_AXI_RRESP  = rresp;
            end
        end
    end

    task automatic wait_ready(output int cyc);
        logic ok;
        ok = 0;
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (SRAM_READY) begin
                ok = 1;
                cyc = i;
                break;
            end
        end
        chk("ready_timeout", ok, 1);
    endtask

    task automatic wait_ack(output int lat);
        logic ok;
        ok = 0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge CLK);
            if (SRAM_ACK) begin
                ok = 1;
                lat = i;
                break;
            end
        end
        chk("ack_timeout", ok, 1);
    endtask

    // Drives one request and queues what the slave and SRAM side must see.
    task automatic drive(input logic we_n, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] ben,
                         input logic e_err, input logic [63:0] e_rd,
                         input logic push_sb);
        exp_t e;
        SRAM_CEn   = 1'b0;
        SRAM_WEn   = we_n;
        SRAM_ADDR  = a;
        SRAM_WDATA = d;
        SRAM_WBEn  = ben;
        if (!we_n) begin
            aw_q.push_back(a & 32'hFFFF_FFF8);
            w_q.push_back({d, ~ben});
        end else begin
            ar_q.push_back(a & 32'hFFFF_FFF8);
            model_rd = e_rd;
        end
        if (push_sb) begin
            e.err   = e_err;
            e.rdata = model_rd;
            sb_q.push_back(e);
            acks_exp++;
        end
    endtask

    task automatic release_req();
        SRAM_CEn   = 1'b1;
        SRAM_WEn   = ~SRAM_WEn;
        SRAM_ADDR  = ~SRAM_ADDR;
        SRAM_WDATA = ~SRAM_WDATA;
        SRAM_WBEn  = ~SRAM_WBEn;
    endtask

    task automatic req(input string tag, input logic we_n,
                       input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] ben, input logic e_err,
                       input logic [63:0] e_rd, input int e_lat);
        int c, lat;
        @(posedge CLK);
        #1;
        drive(we_n, a, d, ben, e_err, e_rd, 1'b1);
        wait_ready(c);
        @(posedge CLK);
        #1;
        release_req();
        wait_ack(lat);
        chk({tag, "_latency"}, lat + 1, e_lat + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, lat, a0;
        logic ok;
        acks_exp  = 0;
        model_rd  = '0;
        aw_delay  = 0; w_delay = 0; b_delay = 0; r_beats = 1;
        bresp     = 2'b00; rresp = 2'b00; bid = 4'h0; rid = 4'h0;
        rdata_cfg = '0;
        SRAM_CEn  = 1'b1; SRAM_WEn = 1'b1; SRAM_ADDR = '0;
        SRAM_WDATA = '0; SRAM_WBEn = '1;
        RESETn = 1'b1;
        #2 RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_ready", SRAM_READY, 1);
        chk("rst_ack_err", {SRAM_ACK, SRAM_ERR}, 2'b00);
        chk("rst_rdata", SRAM_RDATA, 0);
        chk("rst_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID,
            axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 0);
        @(posedge CLK);
        #1 RESETn = 1'b1;

        req("wr_basic", 1'b0, 32'h1000_0008, 64'hDEAD_BEEF_0123_4567,
            8'hF0, 1'b0, 64'h0, 3);

        aw_delay = 4;
        aw_hi = 0; w_hi = 0;
        req("wr_awdelay", 1'b0, 32'h1000_0040, 64'h1111_2222_3333_4444,
            8'h00, 1'b0, 64'h0, 7);
        chk("awvalid_cycles", aw_hi, 5);
        chk("wvalid_cycles", w_hi, 1);
        aw_delay = 0;

        w_delay = 3;
        req("wr_wdelay", 1'b0, 32'h2000_0000, 64'h5555_6666_7777_8888,
            8'h5A, 1'b0, 64'h0, 6);
        w_delay = 0;

        rdata_cfg = 64'h0123_4567_89AB_CDEF;
        req("rd_basic", 1'b1, 32'h0000_0013, 64'h0,
            8'h00, 1'b0, 64'h0123_4567_89AB_CDEF, 3);

        req("wr_hold", 1'b0, 32'h0000_0020, 64'hFFFF_0000_FFFF_0000,
            8'h0F, 1'b0, 64'h0, 3);
        chk("rdata_held", SRAM_RDATA, 64'h0123_4567_89AB_CDEF);

        rresp = 2'b10;
        rdata_cfg = 64'hCAFE_F00D_0000_0001;
        req("rd_slverr", 1'b1, 32'h0000_1000, 64'h0,
            8'h00, 1'b1, 64'hCAFE_F00D_0000_0001, 3);
        rresp = 2'b00;

        rid = 4'h5;
        rdata_cfg = 64'hCAFE_F00D_0000_0002;
        req("rd_badid", 1'b1, 32'h0000_2008, 64'h0,
            8'h00, 1'b1, 64'hCAFE_F00D_0000_0002, 3);
        rid = 4'h0;

        bresp = 2'b11;
        req("wr_decerr", 1'b0, 32'h0000_3000, 64'hABCD_0000_0000_0001,
            8'h00, 1'b1, 64'h0, 3);
        bresp = 2'b00;

        rdata_cfg = 64'h0F0F_0F0F_A5A5_A5A5;
        r_beats = 2;
        req("rd_drain", 1'b1, 32'h0000_4000, 64'h0,
            8'h00, 1'b1, 64'h0F0F_0F0F_A5A5_A5A5, 4);
        r_beats = 1;

        req("rd_ok", 1'b1, 32'h0000_4010, 64'h0,
            8'h00, 1'b0, 64'h0F0F_0F0F_A5A5_A5A5, 3);

        // Back-to-back: CEn stays low, second request taken in ACK cycle.
        @(posedge CLK);
        #1;
        drive(1'b0, 32'h0000_5008, 64'h1234_5678_9ABC_DEF0, 8'hCC,
              1'b0, 64'h0, 1'b1);
        wait_ready(c);
        @(posedge CLK);
        #1;
        rdata_cfg = 64'h7777_8888_9999_AAAA;
        drive(1'b1, 32'h0000_6000, 64'h0, 8'h00,
              1'b0, 64'h7777_8888_9999_AAAA, 1'b1);
        ok = 0;
        c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (SRAM_READY) begin
                ok = 1;
                c = i;
                break;
            end
        end
        chk("b2b_ready_seen", ok, 1);
        chk("b2b_ready_cycle", c, 3);
        chk("b2b_ack_with_ready", SRAM_ACK, 1);
        @(posedge CLK);
        #1;
        release_req();
        wait_ack(lat);
        chk("b2b_rd_latency", lat, 3);

        // Reset while the write sits waiting for B.
        b_delay = 20;
        @(posedge CLK);
        #1;
        drive(1'b0, 32'h0000_0100, 64'h0BAD_0BAD_0BAD_0BAD, 8'h00,
              1'b0, 64'h0, 1'b0);
        wait_ready(c);
        @(posedge CLK);
        #1;
        release_req();
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (axi.M_AXI_BREADY) begin
                ok = 1;
                break;
            end
        end
        chk("rst_in_wresp", ok, 1);
        a0 = ack_cnt;
        #2 RESETn = 1'b0;
        #1;
        chk("rst_async_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID,
            axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 0);
        chk("rst_async_ready", SRAM_READY, 1);
        chk("rst_async_ack", SRAM_ACK, 0);
        repeat (2) @(posedge CLK);
        #1 RESETn = 1'b1;
        b_delay = 0;
        model_rd = '0;
        repeat (5) @(negedge CLK);
        chk("rst_no_ack", ack_cnt, a0);
        chk("rst_rdata_cleared", SRAM_RDATA, 0);

        rdata_cfg = 64'h3141_5926_5358_9793;
        req("rd_after_rst", 1'b1, 32'h0000_7007, 64'h0,
            8'h00, 1'b0, 64'h3141_5926_5358_9793, 3);

        repeat (4) @(negedge CLK);
        chk("bready_before_aw_w", bready_early, 0);
        chk("ack_total", ack_cnt, acks_exp);
        chk("queues_drained", sb_q.size() + aw_q.size() + w_q.size()
            + ar_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
